uart_rx_gpi: RTL
================

Name: uart_rx_gpi

Overview:
- 8N1 UART receiver; the receive-side companion of the team's existing UART transmitter.
- Deserialises `rx_pin` into a one-byte holding register plus status flags.
- The MicroBlaze MCS polls the outputs through a GPI port and acknowledges each byte through a GPO bit.
- Bit timing comes from a run-time `prescaler`, given in clock cycles per bit (2500 in the default build).

Parameters:
- PRESC_W, 16, width of the `prescaler` input.
- SYNC_STAGES, 2, number of flip-flops in the `rx_pin` synchroniser (minimum 2).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous reset, active-low (0 = in reset).
- rx_pin  input  1  serial line; idle high; asynchronous to `clock`.
- prescaler  input  PRESC_W  clock cycles per bit; values below 4 are treated as 4.
- rx_ack  input  1  acknowledge from GPO; a rising edge clears the status flags.
- data  output  8  holding register, the last accepted byte.
- rx_ready  output  1  holding register contains an unread byte.
- overrun  output  1  sticky; a good byte arrived while `rx_ready` was 1.
- frame_err  output  1  sticky; a stop bit was sampled low.
- rx_busy  output  1  high when the FSM is not in IDLE (usable for a LED).

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - `data` = 0x00; `rx_ready`, `overrun`, `frame_err`, `rx_busy` = 0.
  - FSM → IDLE; counters and shift register cleared.
  - Synchroniser flops and the `rx_ack` edge-detect flop set to 1, so no false start or false ack is seen on release.
- Synchroniser: `rx_s` is `rx_pin` delayed by SYNC_STAGES clocks. All decisions use `rx_s` only.
- Prescale latch: at start detection the effective prescaler (P = max(`prescaler`, 4)) is latched. Changes to `prescaler` mid-frame have no effect until the next frame.
- Half-bit value: H = floor(P/2).
- Bit counter: `cnt` counts 0..limit, then restarts at 0.
- FSM states:
  - IDLE: when `rx_s` = 0 (falling level after high) → START, `cnt` = 0.
  - START: when `cnt` = H-1, sample `rx_s`.
    - If 1: glitch → IDLE, no flag.
    - If 0: → DATA, `cnt` = 0, `bitidx` = 0.
  - DATA: when `cnt` = P-1, shift `rx_s` in LSB-first (shift right, new bit into bit 7). `bitidx` increments; after bit 7 → STOP, `cnt` = 0.
  - STOP: when `cnt` = P-1, sample `rx_s`.
    - If 1: deliver the byte (see below) → IDLE.
    - If 0: set `frame_err`, discard the byte → WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then → IDLE. This prevents a break condition from generating repeated frames.
- Sampling points: each sample falls mid-bit, about H+2 clocks after the corresponding edge on `rx_pin`. A new start bit is detectable from the cycle after leaving STOP.
- Delivery, one cycle after the stop sample:
  - If `rx_ready` = 0: `data` ← shift register, `rx_ready` ← 1.
  - If `rx_ready` = 1: `data` is unchanged and `overrun` ← 1.
- Acknowledge: `ack_q` registers `rx_ack`. When `rx_ack` & !`ack_q`, clear `rx_ready`, `overrun`, and `frame_err` in the same cycle. A level held high does not re-clear.
- Simultaneous ack edge and delivery in the same cycle:
  - The ack is applied first.
  - The new byte loads and `rx_ready` stays 1.
  - `overrun` is not set.
  - Flags set by this delivery survive.
- Reset mid-frame: the partial frame is lost. After release the receiver waits for an idle-high line before detecting a start bit; the synchroniser preset guarantees this.
- No parity; exactly 1 stop bit checked; 8 data bits.

Test Plan:
1. Byte reception (P = 16; `rx_pin` stimulus for byte 0x55):
   - Drive 0x55 as 8N1 at 16 clk/bit.
   - `data` = 0x55 and `rx_ready` = 1, asserted 1 cycle after the stop-bit mid-sample.
   - `overrun` = 0, `frame_err` = 0.
   - Pulse `rx_ack` 0→1 → `rx_ready` = 0 on the next edge.
2. Overrun (P = 16):
   - Send 0xA3, do not ack, then send 0x3C.
   - `data` stays 0xA3; `rx_ready` = 1; `overrun` = 1.
   - Ack → all three flags 0.
3. Start-bit glitch (P = 16):
   - Drive `rx_pin` low for 4 clocks, then high.
   - FSM returns to IDLE; `rx_busy` pulses then 0.
   - No `rx_ready` or `frame_err`.
4. Framing error / break (P = 16):
   - Send 0xFF with the stop bit low, then hold the line low for 40 bit times.
   - `frame_err` = 1; `rx_ready` = 0; exactly one error and no further frames.
   - Line high, then send 0x12 → `data` = 0x12, `rx_ready` = 1, `frame_err` still 1 until ack.
5. Simultaneous ack and delivery (P = 16):
   - Hold byte 0x01; time the `rx_ack` rising edge to the cycle in which 0x80 is delivered.
   - `data` = 0x80, `rx_ready` = 1, `overrun` = 0.
6. Reset, prescaler latch and clamping:
   - Assert `reset` = 0 mid-frame (bit 3 of 0xC5) → all outputs 0 asynchronously.
   - Release, line idle, send 0xC5 → `data` = 0xC5.
   - Change `prescaler` 16→32 mid-frame → the current byte is still received at 16 clk/bit.
   - Set `prescaler` = 2, send 0x5A at 4 clk/bit → received as 0x5A.

Source files
------------

// File: rtl/uart_rx_gpi.sv
// 8N1 UART receiver polled by the MCS through GPI; bytes are acknowledged on a GPO bit.
// Bit timing comes from a run-time prescaler (clocks per bit) latched at each start bit.
module uart_rx_gpi #(
    parameter int PRESC_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_pin,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               rx_ack,
    output logic [7:0]         data,
    output logic               rx_ready,
    output logic               overrun,
    output logic               frame_err,
    output logic               rx_busy
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t             state;
    logic [SS-1:0]      sync_q;
    logic               rx_s;
    logic [PRESC_W-1:0] p_eff;
    logic [PRESC_W-1:0] p_lat;
    logic [PRESC_W-1:0] p_m1;
    logic [PRESC_W-1:0] h_m1;
    logic [PRESC_W-1:0] cnt;
    logic [2:0]         bitidx;
    logic [7:0]         shreg;
    logic               del_ok;
    logic               del_fe;
    logic               ack_q;
    logic               ack_edge;
    logic               rdy_a;
    logic               ovr_a;
    logic               fe_a;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SS-2:0], rx_pin};
    end

    assign rx_s  = sync_q[SS-1];
    assign p_eff = (prescaler < PRESC_W'(4)) ? PRESC_W'(4) : prescaler;
    assign p_m1  = p_lat - PRESC_W'(1);
    assign h_m1  = {1'b0, p_lat[PRESC_W-1:1]} - PRESC_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            p_lat  <= PRESC_W'(4);
            bitidx <= '0;
            shreg  <= '0;
            del_ok <= 1'b0;
            del_fe <= 1'b0;
        end else begin
            del_ok <= 1'b0;
            del_fe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        p_lat <= p_eff;
                    end
                end
                S_START: begin
                    if (cnt == h_m1) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        state  <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == p_m1) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitidx <= bitidx + 3'd1;
                        if (bitidx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == p_m1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            del_ok <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            del_fe <= 1'b1;
                            state  <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) yields one error, not a stream of frames.
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

    // Ack clears first, then this cycle's delivery is applied on top.
    always_comb begin
        ack_edge = rx_ack & ~ack_q;
        rdy_a    = rx_ready  & ~ack_edge;
        ovr_a    = overrun   & ~ack_edge;
        fe_a     = frame_err & ~ack_edge;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data      <= '0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            ack_q     <= 1'b1;
        end else begin
            ack_q     <= rx_ack;
            rx_ready  <= rdy_a | del_ok;
            overrun   <= ovr_a | (del_ok & rdy_a);
            frame_err <= fe_a | del_fe;
            if (del_ok && !rdy_a) data <= shreg;
        end
    end

endmodule
